ysyx_22041207_inst_rd_resp: RTL and testbench



---
 rtl/ysyx_22041207_inst_rd_resp.sv | 123 ++++++++++++
 tb/tb_ysyx_22041207_inst_rd_resp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_inst_rd_resp.sv
// Instruction-fetch read responder: accepts one address, waits LAT cycles, returns lane-masked word data.
// Latency: address handshake at edge N -> data_valid high after edge N+LAT+1; back-to-back period LAT+3.
// Backpressure: data held stable in RESP until data_ready; no new address accepted until then.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   r_valid_i/r_ready_o        address handshake; r_addr_i byte address, r_size_i byte-lane keep mask
//   data_valid/data_ready      response handshake; data_read_o (addressed byte at lane 0), data_err
//   wr_en/wr_addr/wr_data      preload write port (8-byte aligned, out-of-range writes dropped)
module ysyx_22041207_inst_rd_resp #(
    parameter logic [63:0] BASE  = 64'h8000_0000,
    parameter int          DEPTH = 4096,
    parameter int          LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [63:0] r_addr_i,
    input  logic [7:0]  r_size_i,
    output logic [63:0] data_read_o,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_err,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [63:0] wr_data
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN    = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT_CNT = 4'(LAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [63:0]   cap_addr;
    logic [7:0]    cap_size;
    logic [63:0]   mem [DEPTH];

    logic [63:0]   rd_off;
    logic          rd_in;
    logic [IW-1:0] rd_idx;
    logic [63:0]   wr_off;
    logic          wr_in;
    logic [IW-1:0] wr_idx;
    logic [63:0]   word;
    logic [63:0]   raw;
    logic [63:0]   rd_data;

    assign rd_off = cap_addr - BASE;
    assign rd_in  = (cap_addr >= BASE) && (rd_off < SPAN);
    assign rd_idx = IW'(rd_off >> 3);

    assign wr_off = wr_addr - BASE;
    assign wr_in  = (wr_addr >= BASE) && (wr_off < SPAN);
    assign wr_idx = IW'(wr_off >> 3);

    // Memory image; deliberately not reset so a preload survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A preload write landing on the response-load edge must be seen by that response,
    // so forward it around the array.
    assign word = (wr_en && wr_in && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    assign raw  = word >> {rd_off[2:0], 3'b000};

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = raw[8*k +: 8] & {8{cap_size[k]}};
        end
    end

    // cnt holds the remaining wait cycles; the response loads on the WAIT edge where it is zero,
    // which gives LAT+1 edges from acceptance to data_valid (one even when LAT is zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_addr    <= '0;
            cap_size    <= '0;
            data_read_o <= '0;
            data_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (r_valid_i) begin
                        cap_addr <= r_addr_i;
                        cap_size <= r_size_i;
                        cnt      <= LAT_CNT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        data_read_o <= rd_in ? rd_data : 64'd0;
                        data_err    <= !rd_in;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (data_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign r_ready_o  = (state == S_IDLE);
    assign data_valid = (state == S_RESP);

endmodule

// File: tb/tb_ysyx_22041207_inst_rd_resp.sv
module tb_ysyx_22041207_inst_rd_resp;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared preload port
    logic        wr_en = 1'b0;
    logic [63:0] wr_addr = '0;
    logic [63:0] wr_data = '0;

    // LAT=2 instance
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [63:0] r_addr = '0;
    logic [7:0]  r_size = '0;
    logic [63:0] data_read;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        data_err;

    // LAT=0 instance
    logic        r_valid0 = 1'b0;
    logic        r_ready0;
    logic [63:0] r_addr0 = '0;
    logic [7:0]  r_size0 = '0;
    logic [63:0] data_read0;
    logic        data_valid0;
    logic        data_ready0 = 1'b0;
    logic        data_err0;

    ysyx_22041207_inst_rd_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_addr_i(r_addr), .r_size_i(r_size),
        .data_read_o(data_read), .data_valid(data_valid), .data_ready(data_ready), .data_err(data_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    ysyx_22041207_inst_rd_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .r_valid_i(r_valid0), .r_ready_o(r_ready0), .r_addr_i(r_addr0), .r_size_i(r_size0),
        .data_read_o(data_read0), .data_valid(data_valid0), .data_ready(data_ready0), .data_err(data_err0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    // Scoreboard monitors: a response is consumed at the next rising edge when both
    // valid and ready are seen high here.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL sb2_spurious: response %h err %b with nothing outstanding", data_read, data_err);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("sb2_data", data_read, e.d);
                check("sb2_err", 64'(data_err), 64'(e.e));
            end
        end
        if (rst_n && data_valid0 && data_ready0) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL sb0_spurious: response %h err %b with nothing outstanding", data_read0, data_err0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("sb0_data", data_read0, e.d);
                check("sb0_err", 64'(data_err0), 64'(e.e));
            end
        end
    end

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // One read on the LAT=2 instance. hold>0 keeps data_ready low for that many cycles
    // after data_valid, and overwrites word 0 partway through to show held data is frozen.
    task automatic rd2(input logic [63:0] a, input logic [7:0] sz,
                       input logic [63:0] ed, input logic ee, input int hold);
        int k;
        logic [63:0] first;
        @(posedge clk); #1;
        r_valid = 1'b1; r_addr = a; r_size = sz; data_ready = (hold == 0);
        k = 0;
        while (!r_ready && k < 20) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;   // acceptance edge
        r_valid = 1'b0; r_addr = 64'hDEAD_DEAD_DEAD_DEAD; r_size = 8'h00;
        q2.push_back('{ed, ee});
        k = 0;
        while (!data_valid && k < 20) begin @(posedge clk); #1; k++; end
        check("lat2_edges", 64'(k), 64'd3);
        check("lat2_rdy_low", 64'(r_ready), 64'd0);
        if (hold > 0) begin
            first = data_read;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                wr_en = (i == 1); wr_addr = BASE; wr_data = 64'd0;
                check("bp_valid", 64'(data_valid), 64'd1);
                check("bp_data", data_read, first);
                check("bp_rdy", 64'(r_ready), 64'd0);
            end
            wr_en = 1'b0;
            data_ready = 1'b1;
        end
        @(posedge clk); #1;   // data handshake edge
        check("done_valid", 64'(data_valid), 64'd0);
        check("done_rdy", 64'(r_ready), 64'd1);
        data_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  size;
        logic [63:0] d;
        logic        e;
    } vec_t;

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{64'h8000_0000, 8'h0F, 64'h0000_0000_5566_7788, 1'b0};
        vecs[1]  = '{64'h8000_0004, 8'h0F, 64'h0000_0000_1122_3344, 1'b0};
        vecs[2]  = '{64'h8000_0004, 8'hFF, 64'h0000_0000_1122_3344, 1'b0};
        vecs[3]  = '{64'h8000_0006, 8'h03, 64'h0000_0000_0000_1122, 1'b0};
        vecs[4]  = '{64'h8000_0008, 8'hFF, 64'hA1A2_A3A4_A5A6_A7A8, 1'b0};
        vecs[5]  = '{64'h8000_0009, 8'hF0, 64'h00A1_A2A3_0000_0000, 1'b0};
        vecs[6]  = '{64'h8000_7FFF, 8'hFF, 64'h0000_0000_0000_00CA, 1'b0};
        vecs[7]  = '{64'h7FFF_FFFC, 8'hFF, 64'h0,                   1'b1};
        vecs[8]  = '{64'h8000_8000, 8'hFF, 64'h0,                   1'b1};
        vecs[9]  = '{64'h8000_0000, 8'h00, 64'h0,                   1'b0};
        vecs[10] = '{64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 1'b0};

        // reset state
        @(posedge clk); #1;
        check("rst_rdy", 64'(r_ready), 64'd1);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_err", 64'(data_err), 64'd0);
        check("rst_data", data_read, 64'd0);
        check("rst_rdy0", 64'(r_ready0), 64'd1);
        check("rst_valid0", 64'(data_valid0), 64'd0);

        // preload, including out-of-range writes that must not alias into the array
        wr(64'h8000_0000, 64'h1122_3344_5566_7788);
        wr(64'h8000_0008, 64'hA1A2_A3A4_A5A6_A7A8);
        wr(64'h8000_7FF8, 64'hCAFE_F00D_DEAD_BEEF);
        wr(64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(64'h7FFF_FFF8, 64'hEEEE_EEEE_EEEE_EEEE);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) rd2(vecs[i].addr, vecs[i].size, vecs[i].d, vecs[i].e, 0);

        // backpressure, with a later write to the same word that must not disturb held data
        rd2(64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 5);
        wr(64'h8000_0000, 64'h1122_3344_5566_7788);

        // reset one cycle after acceptance
        @(posedge clk); #1;
        r_valid = 1'b1; r_addr = 64'h8000_0000; r_size = 8'hFF; data_ready = 1'b1;
        @(posedge clk); #1;   // accepted here
        r_valid = 1'b0;
        check("rw_accepted", 64'(r_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rw_rdy", 64'(r_ready), 64'd1);
        check("rw_valid", 64'(data_valid), 64'd0);
        check("rw_data", data_read, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rw_no_stale", 64'(data_valid), 64'd0);
        end
        data_ready = 1'b0;
        rd2(64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 0);

        // LAT=0 back-to-back with same-word writes on each response-load edge
        @(posedge clk); #1;
        r_valid0 = 1'b1; r_addr0 = 64'h8000_0000; r_size0 = 8'hFF; data_ready0 = 1'b1;
        @(posedge clk); #1;   // edge N: first acceptance
        r_addr0 = 64'h8000_0004;
        wr_en = 1'b1; wr_addr = 64'h8000_0000; wr_data = 64'hDEAD_BEEF_0BAD_F00D;
        q0.push_back('{64'hDEAD_BEEF_0BAD_F00D, 1'b0});
        check("l0_wait_valid", 64'(data_valid0), 64'd0);
        check("l0_wait_rdy", 64'(r_ready0), 64'd0);
        @(posedge clk); #1;   // N+1: load
        wr_en = 1'b0;
        check("l0_lat_first", 64'(data_valid0), 64'd1);
        @(posedge clk); #1;   // N+2: handshake
        check("l0_idle_valid", 64'(data_valid0), 64'd0);
        check("l0_idle_rdy", 64'(r_ready0), 64'd1);
        @(posedge clk); #1;   // N+3: second acceptance
        r_valid0 = 1'b0;
        check("l0_period", 64'(r_ready0), 64'd0);
        wr_en = 1'b1; wr_addr = 64'h8000_0000; wr_data = 64'h5555_6666_7777_8888;
        q0.push_back('{64'h0000_0000_5555_6666, 1'b0});
        @(posedge clk); #1;   // N+4: load
        wr_en = 1'b0;
        check("l0_lat_second", 64'(data_valid0), 64'd1);
        @(posedge clk); #1;
        check("l0_end_rdy", 64'(r_ready0), 64'd1);
        data_ready0 = 1'b0;

        repeat (2) @(posedge clk);
        check("sb2_drain", 64'(q2.size()), 64'd0);
        check("sb0_drain", 64'(q0.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
